// File: rtl/arb_pkg.sv
// Shared arbiter types: FSM state encoding and one-hot to binary index helper.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Widest one-hot vector the helper accepts; arbiters up to 64 ports.
    localparam int ARB_MAX_N = 64;

    // OR-reduce the indices of set bits; exact for one-hot or zero input.
    function automatic logic [31:0] onehot_to_bin(input logic [ARB_MAX_N-1:0] oh);
        logic [31:0] bin;
        bin = '0;
        for (int i = 0; i < ARB_MAX_N; i++) begin
            if (oh[i]) begin
                bin = bin | 32'(i);
            end
        end
        return bin;
    endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Round-robin pick: first set bit of req scanning from ptr upward with wrap.
// Latency: purely combinational.
// Backpressure: none; winner is zero when no request is present.
module rr_arbiter_pick #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic [N-1:0]    winner
);

    localparam int DW = 2 * N;

    logic [N-1:0]  mask;
    logic [DW-1:0] dbl;
    logic [DW-1:0] dbl_lsb;

    // Lower half holds requests at or above ptr, upper half all requests;
    // the lowest set bit of the double-width word is the rotated winner.
    always_comb begin
        mask    = ~((N'(1) << ptr) - N'(1));
        dbl     = {req, req & mask};
        dbl_lsb = dbl & (~dbl + DW'(1));
        winner  = dbl_lsb[N-1:0] | dbl_lsb[DW-1:N];
    end

endmodule

// File: rtl/rr_arbiter_hold.sv
// Round-robin arbiter with registered one-hot grant held across multi-cycle tenures.
// Latency: 1 cycle req->grant; handover to next requester with no idle bubble.
// Backpressure: tenure ends on last, dropped req or hold-limit preemption; waiters stall.
module rr_arbiter_hold
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16,
    parameter int IDXW     = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    last,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [IDXW-1:0] grant_idx,
    output logic            preempt
);

    localparam int              HCW      = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0]  HOLD_LIM = HCW'(MAX_HOLD);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    arb_state_e      state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IDXW-1:0] grant_idx_q, grant_idx_d;
    logic            grant_valid_q, grant_valid_d;
    logic            preempt_q, preempt_d;

    logic            g_req;
    logic            g_last;
    logic            lim_hit;
    logic            rel;
    logic [IDXW-1:0] rel_ptr;
    logic [IDXW-1:0] pick_ptr;
    logic [N-1:0]    winner;

    // Decide whether the current tenure ends this cycle, and which pointer the pick uses.
    always_comb begin
        g_req    = |(req & grant_q);
        g_last   = |(req & last & grant_q);
        lim_hit  = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIM);
        rel      = (state_q == ARB_GRANT) && (!g_req || g_last || lim_hit);
        rel_ptr  = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + IDXW'(1);
        pick_ptr = rel ? rel_ptr : ptr_q;
    end

    rr_arbiter_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .winner (winner)
    );

    // Next-state logic: FSM state, rotation pointer and tenure length counter.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (|winner) begin
                    state_d    = ARB_GRANT;
                    hold_cnt_d = HCW'(1);
                end
            end
            ARB_GRANT: begin
                if (rel) begin
                    ptr_d = rel_ptr;
                    if (|winner) begin
                        hold_cnt_d = HCW'(1);
                    end else begin
                        state_d    = ARB_IDLE;
                        hold_cnt_d = '0;
                    end
                end else if (MAX_HOLD != 0) begin
                    // A held tenure is always below the limit, so this never wraps.
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Output logic: next grant vector, its index, and the preemption pulse.
    always_comb begin
        grant_d   = '0;
        preempt_d = 1'b0;
        case (state_q)
            ARB_IDLE: grant_d = winner;
            ARB_GRANT: begin
                if (rel) begin
                    grant_d   = winner;
                    // Only a pure hold-limit release flags preemption; last wins ties.
                    preempt_d = lim_hit && g_req && !g_last;
                end else begin
                    grant_d = grant_q;
                end
            end
            default: grant_d = '0;
        endcase
        grant_valid_d = |grant_d;
        grant_idx_d   = IDXW'(onehot_to_bin(ARB_MAX_N'(grant_d)));
    end

    // State register: all flops clear asynchronously, requester 0 starts highest priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARB_IDLE;
            ptr_q         <= '0;
            hold_cnt_q    <= '0;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            preempt_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            preempt_q     <= preempt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;
    assign preempt     = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// Directed vector bench for rr_arbiter_hold with N=4, MAX_HOLD=4.
// Latency: each vector's outputs are checked one cycle after its inputs.
// Backpressure: not applicable.
module tb_rr_arbiter_hold;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] last;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic       preempt;

    int n_cmp;
    int n_err;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] last;
        logic [3:0] grant;
        logic [1:0] idx;
        logic       vld;
        logic       pre;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs [NV];

    rr_arbiter_hold #(
        .N        (4),
        .MAX_HOLD (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .last        (last),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .preempt     (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] l);
        req  = r;
        last = l;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] g, input logic [1:0] idx,
                             input logic vld, input logic pre);
        check({tag, " grant"}, grant, g);
        check({tag, " grant_idx"}, 4'(grant_idx), 4'(idx));
        check({tag, " grant_valid"}, 4'(grant_valid), 4'(vld));
        check({tag, " preempt"}, 4'(preempt), 4'(pre));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        //              req      last     grant    idx   vld   pre
        // first grant, then last[0] hands over with no bubble
        vecs[0]  = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[1]  = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[2]  = '{4'b1111, 4'b0001, 4'b0010, 2'd1, 1'b1, 1'b0};
        // fairness rotation, last on every bit (non-granted bits ignored)
        vecs[3]  = '{4'b1111, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[4]  = '{4'b1111, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[5]  = '{4'b1111, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[6]  = '{4'b1111, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0};
        // requester 1 drops, nobody else: idle; then 0011 wraps from ptr 2 to 0
        vecs[7]  = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[8]  = '{4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
        // preemption ping-pong between 2 and 3, four cycles each
        vecs[9]  = '{4'b1100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[10] = '{4'b1100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[11] = '{4'b1100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[12] = '{4'b1100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[13] = '{4'b1100, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b1};
        vecs[14] = '{4'b1100, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[15] = '{4'b1100, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[16] = '{4'b1100, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[17] = '{4'b1100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b1};
        // sole requester 2: grant held continuously, preempt every 4 cycles
        vecs[18] = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[19] = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[20] = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[21] = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b1};
        vecs[22] = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[23] = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[24] = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
        // last coincides with the hold limit: last wins, no preempt
        vecs[25] = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
        // wrap: ptr is 3, req 1001 -> 3, then release -> 0
        vecs[26] = '{4'b1001, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[27] = '{4'b1001, 4'b1000, 4'b0001, 2'd0, 1'b1, 1'b0};
        // last on non-granted bits only: grant holds; then all drop
        vecs[28] = '{4'b1111, 4'b1110, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[29] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

        rst_n = 1'b0;
        req   = '0;
        last  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].req, vecs[i].last);
            check_all($sformatf("v%0d", i), vecs[i].grant, vecs[i].idx, vecs[i].vld, vecs[i].pre);
        end

        // Idle with ptr = 1: requester 2 wins, runs to the limit and is re-granted.
        step(4'b0100, 4'b0000);
        check("rst_seq first grant", grant, 4'b0100);
        repeat (3) step(4'b0100, 4'b0000);
        step(4'b0100, 4'b0000);
        check("rst_seq regrant", grant, 4'b0100);
        check("rst_seq preempt before reset", 4'(preempt), 4'd1);

        // Asynchronous reset mid-tenure: outputs clear before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;

        // Pointer returned to 0, so requester 0 wins rather than 3.
        step(4'b1111, 4'b0000);
        check_all("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
